hex_rate_counter: RTL

Rate-divided 4-bit hex counter that produces the nibble consumed by the 7-segment hex decoder stage. A programmable divider turns the 50 MHz board clock into a step strobe at one of four rates. The counter then steps up or down and wraps modulo 16, with synchronous parallel load. Its `Q` output wires directly to the decoder's 4-bit input, giving a visibly counting HEX digit.

---
 rtl/hex_counter_pkg.sv | 22 ++
 rtl/rate_divider.sv | 35 +++
 rtl/hex_rate_counter.sv | 67 ++++++
 3 files changed

// File: rtl/hex_counter_pkg.sv
// Shared encodings and reload arithmetic for the rate-divided hex counter.
package hex_counter_pkg;

  localparam logic [1:0] SPD_FULL    = 2'b00;
  localparam logic [1:0] SPD_1HZ     = 2'b01;
  localparam logic [1:0] SPD_HALF    = 2'b10;
  localparam logic [1:0] SPD_QUARTER = 2'b11;

  // Divider reload for a given rate; period in cycles is the return value + 1.
  function automatic logic [63:0] reload_val(input logic [1:0] speed,
                                             input int unsigned ticks);
    logic [63:0] t;
    t = 64'(ticks);
    case (speed)
      SPD_FULL:    reload_val = '0;
      SPD_1HZ:     reload_val = t - 64'd1;
      SPD_HALF:    reload_val = (t << 1) - 64'd1;
      default:     reload_val = (t << 2) - 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Programmable down-counting divider; Strobe marks the enabled cycle where div hits zero.
module rate_divider
  import hex_counter_pkg::*;
#(
  parameter int TICKS_1HZ = 50_000_000,
  parameter int DIV_W     = 28
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Reload,
  input  logic [1:0] Speed,
  output logic       Strobe
);

  logic [DIV_W-1:0] div_q, div_d, reload;

  always_comb begin
    reload = DIV_W'(reload_val(Speed, TICKS_1HZ));
    div_d  = div_q;
    if (Reload)
      div_d = reload;
    else if (Enable)
      div_d = (div_q == '0) ? reload : div_q - DIV_W'(1);
  end

  // Internal only; the top registers everything it exposes.
  assign Strobe = Enable && (div_q == '0);

  always_ff @(posedge Clock) begin
    if (Reset) div_q <= reload;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/hex_rate_counter.sv
// Up/down modulo-16 counter stepped by rate_divider, with parallel load and registered pulses.
module hex_rate_counter
  import hex_counter_pkg::*;
#(
  parameter int TICKS_1HZ = 50_000_000,
  parameter int DIV_W     = 28
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [1:0] Speed,
  input  logic       Up,
  input  logic       Load,
  input  logic [3:0] LoadVal,
  output logic [3:0] Q,
  output logic       Tick,
  output logic       Wrap
);

  logic       strobe;
  logic [3:0] q_q, q_d;
  logic       tick_q, tick_d;
  logic       wrap_q, wrap_d;

  rate_divider #(
    .TICKS_1HZ (TICKS_1HZ),
    .DIV_W     (DIV_W)
  ) u_div (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .Reload (Load),
    .Speed  (Speed),
    .Strobe (strobe)
  );

  // Load wins over a coincident strobe, which is simply dropped.
  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (Load) begin
      q_d = LoadVal;
    end else if (strobe) begin
      q_d    = Up ? q_q + 4'd1 : q_q - 4'd1;
      tick_d = 1'b1;
      wrap_d = Up ? (q_q == 4'hF) : (q_q == 4'h0);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q    <= 4'h0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Tick = tick_q;
  assign Wrap = wrap_q;

endmodule
